// File: rtl/nvsram_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nvsram_pkg                                                           |
// | Shared types and sizes for the NV-SRAM host-side controller.         |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package nvsram_pkg;

   // Word count of the attached macro; addresses at or above are rejected
   localparam int DEPTH_DEF = 136;

   // Macro address and data bus widths
   localparam int ADDR_W = 8;
   localparam int DATA_W = 32;

   // Request opcodes as carried on REQ_OP
   typedef enum logic [1:0] {
      OP_READ   = 2'd0,
      OP_WRITE  = 2'd1,
      OP_STORE  = 2'd2,
      OP_RECALL = 2'd3
   } op_t;

   // Controller sequencing states
   typedef enum logic [2:0] {
      IDLE          = 3'd0,
      RD_ISSUE      = 3'd1,
      RD_CAPT       = 3'd2,
      WR            = 3'd3,
      NV_PULSE      = 3'd4,
      NV_WAIT_START = 3'd5,
      NV_WAIT_DONE  = 3'd6,
      RESP          = 3'd7
   } state_t;

endpackage
`default_nettype wire

// File: rtl/nvsram_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nvsram_ctrl                                                          |
// | Single-outstanding request controller for a 136x32 NV-SRAM macro:    |
// | word read/write plus whole-array store/recall with busy tracking.    |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module nvsram_ctrl
   import nvsram_pkg::*;
#(
   parameter int DEPTH      = DEPTH_DEF,
   parameter int START_WIN  = 4,
   parameter int NV_TIMEOUT = 1024
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              REQ_VALID,
   output logic              REQ_READY,
   input  logic [1:0]        REQ_OP,
   input  logic [ADDR_W-1:0] REQ_ADDR,
   input  logic [DATA_W-1:0] REQ_WDATA,
   output logic              RSP_VALID,
   input  logic              RSP_READY,
   output logic [DATA_W-1:0] RSP_RDATA,
   output logic              RSP_ERR,
   output logic              MEM_CE,
   output logic              MEM_WE,
   output logic [ADDR_W-1:0] MEM_A,
   output logic [DATA_W-1:0] MEM_DIN,
   output logic              MEM_HS,
   output logic              MEM_HR,
   input  logic [DATA_W-1:0] MEM_DOUT,
   input  logic              MEM_BUSYNVC,
   output logic              BUSY
);

   localparam int                  CNT_W        = $clog2(NV_TIMEOUT + 1);
   localparam logic [CNT_W-1:0]    CNT_MAX      = '1;
   localparam logic [CNT_W-1:0]    START_LAST   = CNT_W'(START_WIN - 1);
   localparam logic [CNT_W-1:0]    TIMEOUT_LAST = CNT_W'(NV_TIMEOUT - 1);
   localparam logic [ADDR_W:0]     DEPTH_L      = (ADDR_W + 1)'(DEPTH);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             addr_bad;

   // Only word accesses carry a meaningful address
   assign addr_bad = (op_t'(REQ_OP) == OP_READ || op_t'(REQ_OP) == OP_WRITE) &&
                     ({1'b0, REQ_ADDR} >= DEPTH_L);

   // Sequencer: every output is set on the edge that enters the state it belongs to
   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= IDLE;
         cnt       <= '0;
         REQ_READY <= 1'b1;
         RSP_VALID <= 1'b0;
         RSP_RDATA <= '0;
         RSP_ERR   <= 1'b0;
         BUSY      <= 1'b0;
         MEM_CE    <= 1'b0;
         MEM_WE    <= 1'b0;
         MEM_A     <= '0;
         MEM_DIN   <= '0;
         MEM_HS    <= 1'b0;
         MEM_HR    <= 1'b0;
      end else begin
         // Strobes last a single cycle; states that need them re-assert below
         MEM_WE  <= 1'b0;
         MEM_DIN <= '0;
         MEM_HS  <= 1'b0;
         MEM_HR  <= 1'b0;
         if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
         end

         case (state)
            IDLE: begin
               if (REQ_VALID) begin
                  REQ_READY <= 1'b0;
                  BUSY      <= 1'b1;
                  RSP_RDATA <= '0;
                  RSP_ERR   <= 1'b0;
                  if (addr_bad) begin
                     state     <= RESP;
                     RSP_VALID <= 1'b1;
                     RSP_ERR   <= 1'b1;
                  end else begin
                     case (op_t'(REQ_OP))
                        OP_READ: begin
                           state  <= RD_ISSUE;
                           MEM_CE <= 1'b1;
                           MEM_A  <= REQ_ADDR;
                        end
                        OP_WRITE: begin
                           state   <= WR;
                           MEM_CE  <= 1'b1;
                           MEM_WE  <= 1'b1;
                           MEM_A   <= REQ_ADDR;
                           MEM_DIN <= REQ_WDATA;
                        end
                        OP_STORE: begin
                           state  <= NV_PULSE;
                           MEM_CE <= 1'b1;
                           MEM_HS <= 1'b1;
                        end
                        default: begin
                           state  <= NV_PULSE;
                           MEM_CE <= 1'b1;
                           MEM_HR <= 1'b1;
                        end
                     endcase
                  end
               end
            end
            RD_ISSUE: begin
               // CE and A are held so the macro's DOUT survives into the capture cycle
               state <= RD_CAPT;
            end
            RD_CAPT: begin
               state     <= RESP;
               RSP_VALID <= 1'b1;
               RSP_RDATA <= MEM_DOUT;
               MEM_CE    <= 1'b0;
               MEM_A     <= '0;
            end
            WR: begin
               state     <= RESP;
               RSP_VALID <= 1'b1;
               MEM_CE    <= 1'b0;
               MEM_A     <= '0;
            end
            NV_PULSE: begin
               state  <= NV_WAIT_START;
               cnt    <= '0;
               MEM_CE <= 1'b0;
            end
            NV_WAIT_START: begin
               // Busy seen on the final window edge still wins over "instantaneous"
               if (MEM_BUSYNVC) begin
                  state <= NV_WAIT_DONE;
                  cnt   <= '0;
               end else if (cnt >= START_LAST) begin
                  state     <= RESP;
                  RSP_VALID <= 1'b1;
               end
            end
            NV_WAIT_DONE: begin
               if (!MEM_BUSYNVC) begin
                  state     <= RESP;
                  RSP_VALID <= 1'b1;
               end else if (cnt >= TIMEOUT_LAST) begin
                  state     <= RESP;
                  RSP_VALID <= 1'b1;
                  RSP_ERR   <= 1'b1;
               end
            end
            RESP: begin
               if (RSP_READY) begin
                  state     <= IDLE;
                  RSP_VALID <= 1'b0;
                  RSP_RDATA <= '0;
                  RSP_ERR   <= 1'b0;
                  REQ_READY <= 1'b1;
                  BUSY      <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_nvsram_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_nvsram_ctrl                                                       |
// | Randomised bench for nvsram_ctrl with a behavioural macro and a      |
// | latency/data reference model derived from the request rules.         |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_nvsram_ctrl;
   import nvsram_pkg::*;

   localparam int DEPTH      = 136;
   localparam int START_WIN  = 4;
   localparam int NV_TIMEOUT = 1024;
   localparam int BUDGET     = 3000;

   logic        CLK = 1'b0;
   logic        RST;
   logic        REQ_VALID;
   logic        REQ_READY;
   logic [1:0]  REQ_OP;
   logic [7:0]  REQ_ADDR;
   logic [31:0] REQ_WDATA;
   logic        RSP_VALID;
   logic        RSP_READY;
   logic [31:0] RSP_RDATA;
   logic        RSP_ERR;
   logic        MEM_CE;
   logic        MEM_WE;
   logic [7:0]  MEM_A;
   logic [31:0] MEM_DIN;
   logic        MEM_HS;
   logic        MEM_HR;
   logic [31:0] MEM_DOUT;
   logic        MEM_BUSYNVC;
   logic        BUSY;

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   nvsram_ctrl #(
      .DEPTH      (DEPTH),
      .START_WIN  (START_WIN),
      .NV_TIMEOUT (NV_TIMEOUT)
   ) dut (
      .CLK         (CLK),
      .RST         (RST),
      .REQ_VALID   (REQ_VALID),
      .REQ_READY   (REQ_READY),
      .REQ_OP      (REQ_OP),
      .REQ_ADDR    (REQ_ADDR),
      .REQ_WDATA   (REQ_WDATA),
      .RSP_VALID   (RSP_VALID),
      .RSP_READY   (RSP_READY),
      .RSP_RDATA   (RSP_RDATA),
      .RSP_ERR     (RSP_ERR),
      .MEM_CE      (MEM_CE),
      .MEM_WE      (MEM_WE),
      .MEM_A       (MEM_A),
      .MEM_DIN     (MEM_DIN),
      .MEM_HS      (MEM_HS),
      .MEM_HR      (MEM_HR),
      .MEM_DOUT    (MEM_DOUT),
      .MEM_BUSYNVC (MEM_BUSYNVC),
      .BUSY        (BUSY)
   );

   // Macro stand-in: registered DOUT, cleared whenever CE drops
   logic [31:0] macro_mem [DEPTH] = '{default: '0};
   logic [31:0] macro_dout;
   assign MEM_DOUT = macro_dout;

   always @(posedge CLK or negedge MEM_CE) begin
      if (!MEM_CE) begin
         macro_dout <= '0;
      end else if (MEM_WE) begin
         if (int'(MEM_A) < DEPTH) macro_mem[MEM_A] <= MEM_DIN;
      end else begin
         macro_dout <= (int'(MEM_A) < DEPTH) ? macro_mem[MEM_A] : '0;
      end
   end

   // Reference contents of the array as seen by the host
   logic [31:0] exp_mem [DEPTH] = '{default: '0};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // One request/response; d = cycles after the pulse before BUSYNVC rises
   // (beyond the start window means it never rises), len = cycles it stays high,
   // bp = cycles of response back-pressure
   task automatic run_req(input logic [1:0] op, input logic [7:0] addr,
                          input logic [31:0] wd, input int d, input int len, input int bp);
      logic        bad, nv, nv_rise, exp_err;
      logic [31:0] exp_data, hold_data;
      logic        hold_err;
      int          exp_lat, exp_ce, exp_hs, exp_hr, exp_we;
      int          ce_n, hs_n, hr_n, we_n, pin_bad, stable_bad, k;

      bad     = (op == OP_READ || op == OP_WRITE) && int'(addr) >= DEPTH;
      nv      = (op == OP_STORE || op == OP_RECALL);
      nv_rise = nv && (d <= START_WIN - 1);
      exp_err = 1'b0; exp_data = '0;
      exp_ce = 0; exp_hs = 0; exp_hr = 0; exp_we = 0;
      if (bad) begin
         exp_lat = 1; exp_err = 1'b1;
      end else if (op == OP_READ) begin
         exp_lat = 3; exp_ce = 2; exp_data = exp_mem[addr];
      end else if (op == OP_WRITE) begin
         exp_lat = 2; exp_ce = 1; exp_we = 1;
      end else begin
         exp_ce = 1;
         if (op == OP_STORE) exp_hs = 1; else exp_hr = 1;
         if (!nv_rise)               exp_lat = START_WIN + 2;
         else if (len <= NV_TIMEOUT) exp_lat = d + len + 3;
         else begin
            exp_lat = d + NV_TIMEOUT + 3; exp_err = 1'b1;
         end
      end

      ce_n = 0; hs_n = 0; hr_n = 0; we_n = 0; pin_bad = 0; stable_bad = 0;
      RSP_READY = (bp == 0);
      REQ_VALID = 1'b1; REQ_OP = op; REQ_ADDR = addr; REQ_WDATA = wd;
      @(posedge CLK); #1;
      REQ_VALID = 1'b0;
      for (k = 0; k < BUDGET; k++) begin
         MEM_BUSYNVC = nv_rise && (k >= 1 + d) && (k < 1 + d + len);
         if (MEM_CE) begin
            ce_n++;
            if (!nv && MEM_A !== addr) pin_bad++;
         end
         if (MEM_WE) begin
            we_n++;
            if (MEM_DIN !== wd) pin_bad++;
         end
         if (MEM_HS) hs_n++;
         if (MEM_HR) hr_n++;
         if (RSP_VALID) break;
         @(posedge CLK); #1;
      end
      MEM_BUSYNVC = 1'b0;
      if (!RSP_VALID) begin
         check("rsp_wait_bound", 32'(RSP_VALID), 32'd1);
         return;
      end
      check("latency", 32'(k + 1), 32'(exp_lat));
      check("rdata",   RSP_RDATA, exp_data);
      check("err",     32'(RSP_ERR), 32'(exp_err));
      check("ce_cycles", 32'(ce_n), 32'(exp_ce));
      check("we_cycles", 32'(we_n), 32'(exp_we));
      check("hs_cycles", 32'(hs_n), 32'(exp_hs));
      check("hr_cycles", 32'(hr_n), 32'(exp_hr));
      check("addr_din_pins", 32'(pin_bad), 32'd0);

      hold_data = RSP_RDATA; hold_err = RSP_ERR;
      for (int i = 0; i < bp; i++) begin
         @(posedge CLK); #1;
         if (!RSP_VALID || RSP_RDATA !== hold_data || RSP_ERR !== hold_err || REQ_READY)
            stable_bad++;
      end
      if (bp > 0) check("backpressure_stable", 32'(stable_bad), 32'd0);
      RSP_READY = 1'b1;
      @(posedge CLK); #1;
      check("after_handshake", {29'd0, RSP_VALID, BUSY, REQ_READY}, 32'd1);

      if (op == OP_WRITE && !bad) exp_mem[addr] = wd;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [1:0] rop;
      logic [7:0] raddr;
      int         sel;

      RST = 1'b1; REQ_VALID = 1'b0; REQ_OP = '0; REQ_ADDR = '0; REQ_WDATA = '0;
      RSP_READY = 1'b1; MEM_BUSYNVC = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      check("reset_ctl", {24'd0, RSP_VALID, RSP_ERR, BUSY, MEM_CE, MEM_WE, MEM_HS, MEM_HR, REQ_READY}, 32'd1);
      check("reset_a_din_rdata", {MEM_A, 24'd0} | MEM_DIN | RSP_RDATA, 32'd0);
      RST = 1'b0;
      @(posedge CLK); #1;

      // Directed scenarios
      run_req(OP_WRITE,  8'd5,   32'hDEADBEEF, 9, 0, 0);
      run_req(OP_READ,   8'd5,   32'h0,        9, 0, 0);
      run_req(OP_READ,   8'd136, 32'h0,        9, 0, 0);
      run_req(OP_WRITE,  8'd255, 32'h12345678, 9, 0, 0);
      run_req(OP_STORE,  8'd0,   32'h0,        0, 10, 0);
      run_req(OP_RECALL, 8'd0,   32'h0,        9, 0, 0);
      run_req(OP_STORE,  8'd0,   32'h0,        3, 7, 0);
      run_req(OP_STORE,  8'd0,   32'h0,        0, 100000, 0);
      run_req(OP_READ,   8'd5,   32'h0,        9, 0, 5);
      run_req(OP_WRITE,  8'd135, 32'hA5A5_5A5A, 9, 0, 2);
      run_req(OP_READ,   8'd135, 32'h0,        9, 0, 0);

      // Reset during the capture cycle of a read
      RSP_READY = 1'b1;
      REQ_VALID = 1'b1; REQ_OP = OP_READ; REQ_ADDR = 8'd5;
      @(posedge CLK); #1;
      REQ_VALID = 1'b0;
      @(posedge CLK); #1;
      check("rdcapt_ce_high", 32'(MEM_CE), 32'd1);
      RST = 1'b1;
      @(posedge CLK); #1;
      RST = 1'b0;
      check("midop_reset_ctl", {24'd0, RSP_VALID, RSP_ERR, BUSY, MEM_CE, MEM_WE, MEM_HS, MEM_HR, REQ_READY}, 32'd1);
      check("midop_reset_data", {MEM_A, 24'd0} | MEM_DIN | RSP_RDATA, 32'd0);
      sel = 0;
      repeat (4) begin
         @(posedge CLK); #1;
         if (RSP_VALID) sel++;
      end
      check("no_rsp_after_reset", 32'(sel), 32'd0);

      // Randomised traffic
      for (int n = 0; n < 60; n++) begin
         rop = 2'($urandom_range(0, 3));
         sel = $urandom_range(0, 9);
         if (sel < 7)       raddr = 8'($urandom_range(0, 15));
         else if (sel == 7) raddr = 8'($urandom_range(136, 255));
         else               raddr = 8'($urandom_range(0, 135));
         run_req(rop, raddr, $urandom, $urandom_range(0, 5), $urandom_range(1, 20),
                 ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
